// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 register bank family: default widths,
// register index names and the read-select width helper.
package td4_pkg;

    localparam int TD4_DATA_W = 4;
    localparam int TD4_PC_W   = 4;

    localparam int REG_A = 0;
    localparam int REG_B = 1;

    // Smallest select width able to address n registers, never below one bit.
    function automatic int td4_sel_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/td4_pc_counter.sv
// Program counter with jump load and a registered one-cycle wrap pulse.
module td4_pc_counter
    import td4_pkg::*;
#(
    parameter int PC_WIDTH = TD4_PC_W
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                EN,
    input  logic                PC_LD,
    input  logic [PC_WIDTH-1:0] LOAD_VAL,
    output logic [PC_WIDTH-1:0] PC,
    output logic                PC_WRAP
);

    logic [PC_WIDTH-1:0] pc_q;
    logic                wrap_q;

    // A jump always clears the wrap pulse, even a jump to zero; only the
    // increment from all-ones raises it. With EN low the pulse is held.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            pc_q   <= '0;
            wrap_q <= 1'b0;
        end else if (EN) begin
            if (PC_LD) begin
                pc_q   <= LOAD_VAL;
                wrap_q <= 1'b0;
            end else begin
                pc_q   <= pc_q + PC_WIDTH'(1);
                wrap_q <= &pc_q;
            end
        end
    end

    assign PC      = pc_q;
    assign PC_WRAP = wrap_q;

endmodule

// File: rtl/td4_reg_bank.sv
// TD4 register bank: NUM_REGS general registers, program counter, carry flag
// and a sticky error for writes that strobe more than one register.
module td4_reg_bank
    import td4_pkg::*;
#(
    parameter  int WIDTH    = TD4_DATA_W,
    parameter  int NUM_REGS = 2,
    parameter  int PC_WIDTH = TD4_PC_W,
    localparam int SEL_W    = td4_sel_w(NUM_REGS)
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      EN,
    input  logic [NUM_REGS-1:0]       LD,
    input  logic [WIDTH-1:0]          D,
    input  logic [SEL_W-1:0]          RSEL,
    output logic [WIDTH-1:0]          RDATA,
    output logic [NUM_REGS*WIDTH-1:0] REGS,
    input  logic                      PC_LD,
    output logic [PC_WIDTH-1:0]       PC,
    input  logic                      C_IN,
    output logic                      C_OUT,
    output logic                      PC_WRAP,
    output logic                      ERR
);

    localparam int EXT_W = (WIDTH > PC_WIDTH) ? WIDTH : PC_WIDTH;

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic                carry_q;
    logic                err_q;
    logic                ld_multi;
    logic [EXT_W-1:0]    d_ext;
    logic [PC_WIDTH-1:0] pc_load;

    // Clearing the lowest set bit leaves something only when two or more
    // strobes are active at once.
    assign ld_multi = (LD & (LD - NUM_REGS'(1))) != '0;

    assign d_ext   = EXT_W'(D);
    assign pc_load = d_ext[PC_WIDTH-1:0];

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (EN) begin
            if (!ld_multi) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (LD[i]) begin
                        regs_q[i] <= D;
                    end
                end
            end else begin
                err_q <= 1'b1;
            end
            carry_q <= C_IN;
        end
    end

    // Out-of-range selects fall through to the zero default.
    always_comb begin
        RDATA = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RSEL == SEL_W'(i)) begin
                RDATA = regs_q[i];
            end
        end
    end

    always_comb begin
        REGS = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            REGS[i*WIDTH +: WIDTH] = regs_q[i];
        end
    end

    td4_pc_counter #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc (
        .CLK      (CLK),
        .CLR      (CLR),
        .EN       (EN),
        .PC_LD    (PC_LD),
        .LOAD_VAL (pc_load),
        .PC       (PC),
        .PC_WRAP  (PC_WRAP)
    );

    assign C_OUT = carry_q;
    assign ERR   = err_q;

endmodule

// File: doc/td4_reg_bank.md
Name: td4_reg_bank

Overview:
- Parametrised successor to the TD4 single-register blocks: one block holding NUM_REGS general registers, the program counter and the carry flag.
- Sits between the instruction decoder/ALU and the data-selector mux.
- Adds what the fixed 4-bit single-register blocks lack: register count/width parameters, a global clock enable, a PC with jump load and wrap detection, a registered carry flag, and a sticky error on illegal multi-register writes.

Parameters:
- WIDTH, 4: data width of each general register and of D.
- NUM_REGS, 2: number of general registers (reg 0 = A, reg 1 = B); legal range 1..16.
- PC_WIDTH, 4: program counter width.
- SEL_W, derived localparam, max(1, clog2(NUM_REGS)): read-select width.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  reset; asynchronous, active-high.
- EN  in  1  global clock enable (step/halt); low freezes all state.
- LD  in  NUM_REGS  per-register write strobe, active-high, intended one-hot.
- D  in  WIDTH  write data (ALU result) for registers and PC jump.
- RSEL  in  SEL_W  read select.
- RDATA  out  WIDTH  selected register contents, combinational.
- REGS  out  NUM_REGS*WIDTH  all registers flattened, reg i at bits [i*WIDTH +: WIDTH].
- PC_LD  in  1  jump: load PC from D.
- PC  out  PC_WIDTH  current program counter.
- C_IN  in  1  carry out of ALU for the current instruction.
- C_OUT  out  1  registered carry flag.
- PC_WRAP  out  1  one-cycle pulse: PC wrapped by increment.
- ERR  out  1  sticky illegal-write flag.

Behaviour:
- CLR high, asynchronously: all registers, PC, C_OUT, PC_WRAP and ERR go to 0 and are held at 0 while CLR is high. The first update happens on the first rising CLK edge after CLR falls.
- All state updates occur on the rising CLK edge only when EN=1. When EN=0 nothing changes, including PC_WRAP, which holds its value.
- Register write:
  - If exactly one LD bit is set, that register takes D.
  - If LD is zero, all registers hold.
  - If more than one LD bit is set, no register is written and ERR is set. ERR stays high until CLR.
- PC update, one per enabled edge:
  - PC_LD=1: PC takes D. If PC_WIDTH < WIDTH, use the low PC_WIDTH bits; otherwise zero-extend.
  - PC_LD=0: PC takes PC+1 modulo 2^PC_WIDTH.
- PC_WRAP is registered. It is 1 for the cycle after an enabled increment from all-ones to 0, otherwise 0.
  - A jump to 0 never raises PC_WRAP.
  - Jump and register write in the same cycle are independent; both take effect.
- Carry flag: C_OUT takes C_IN on every enabled edge (TD4 semantics: the flag reflects the last instruction). The JNC decision stays external.
- Read path: RDATA = register[RSEL], combinational, zero latency. RSEL >= NUM_REGS reads 0.
- A write to a register is visible on RDATA/REGS the cycle after the edge. There is no write-through bypass.
- Reset mid-operation: CLR asserted between edges clears immediately. A pending LD/PC_LD on that cycle is discarded.
- No X propagation: every output is driven from reset onward.

Decomposition:
- Shared package td4_pkg holds:
  - default widths (TD4_DATA_W=4, TD4_PC_W=4);
  - register index constants (REG_A=0, REG_B=1);
  - a clog2 helper for SEL_W.
- One sub-module is natural: td4_pc_counter. It takes CLK, CLR, EN, PC_LD and a load value, and outputs PC and PC_WRAP.
- The register array, LD legality check and carry flag stay in the top block.

Test Plan:
- Reset: CLR=1 mid-run with PC=9, A=5, ERR=1 -> all outputs 0 immediately, without waiting for a CLK edge. Release CLR, EN=1, no LD -> PC=1 after 1 edge.
- Register writes: LD=01, D=0xA, then LD=10, D=0x3, EN=1 -> REGS=0x3A; RSEL=0 gives RDATA=0xA, RSEL=1 gives 0x3. The edge with EN=0 and LD=01, D=0xF leaves REGS unchanged.
- Illegal write: A=0x2, B=0x7, then LD=11, D=0xC -> REGS unchanged (0x72), ERR=1 and still 1 after 5 further clean cycles.
- PC wrap: 15 increments from 0 -> PC=0xF; next edge -> PC=0, PC_WRAP=1 for exactly one cycle. Separately, PC_LD=1 with D=0 from PC=0x7 -> PC=0, PC_WRAP=0.
- Jump/write concurrency: PC_LD=1, LD=01, D=0x6 in the same cycle -> PC=6 and A=6 after one edge. With WIDTH=8, PC_WIDTH=4, D=0xB3 -> PC=0x3.
- Carry: C_IN sequence 1,0,1 with EN pattern 1,0,1 -> C_OUT 1,1,1. Next enabled edge with C_IN=0 -> C_OUT=0.
